// File: rtl/spi_shift_pkg.sv
// Shared types and helpers for the SPI shift engine datapath.
package spi_shift_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} spi_shift_state_e;

  localparam int SPI_DATA_W_DEF = 32;

  // A length of 0 or anything wider than the frame means "full width".
  function automatic int spi_len_clamp(input int len, input int data_w);
    return (len == 0 || len > data_w) ? data_w : len;
  endfunction

endpackage

// File: rtl/spi_shift_rx.sv
// Receive shift register: captures sdi on sample strobes and publishes an
// aligned word on the frame's final shift.
module spi_shift_rx
  import spi_shift_pkg::*;
#(
  parameter  int DATA_W = SPI_DATA_W_DEF,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_load,
  input  logic              i_smp,
  input  logic              i_sdi,
  input  logic              i_lsb_first,
  input  logic [CNT_W-1:0]  i_len,
  input  logic              i_fin,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid
);

  logic [DATA_W-1:0] r_rx_q;
  logic [DATA_W-1:0] w_rx_nxt;

  // A sample coinciding with the final shift must still land in the word.
  always_comb begin
    w_rx_nxt = r_rx_q;
    if (i_smp)
      w_rx_nxt = i_lsb_first ? {i_sdi, r_rx_q[DATA_W-1:1]}
                             : {r_rx_q[DATA_W-2:0], i_sdi};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rx_q     <= '0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
    end else begin
      o_rx_valid <= i_fin;
      if (i_load) r_rx_q <= '0;
      else        r_rx_q <= w_rx_nxt;
      // LSB-first bits enter at the top, so short frames need right-aligning.
      if (i_fin)
        o_rx_data <= i_lsb_first ? (w_rx_nxt >> (DATA_W - int'(i_len))) : w_rx_nxt;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// Parametrised SPI serial shift engine with optional full-duplex receive path.
// Define SPI_SHIFT_RX_EN to build the receive path.
module spi_shift_engine
  import spi_shift_pkg::*;
#(
  parameter  int DATA_W = SPI_DATA_W_DEF,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CNT_W-1:0]  len_i,
  input  logic              lsb_first_i,
  input  logic              sh_en_i,
  input  logic              smp_en_i,
  input  logic              sdi_i,
  output logic              sdo_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o
);

  spi_shift_state_e  r_state, w_state_nxt;
  logic [DATA_W-1:0] r_tx_q;
  logic [CNT_W-1:0]  r_cnt, r_len, w_len;
  logic              r_lsb;
  logic              w_load, w_shift, w_sample, w_last;

  assign w_len    = CNT_W'(spi_len_clamp(int'(len_i), DATA_W));
  assign w_load   = (r_state == IDLE) && valid_i;
  assign w_shift  = (r_state == ACTIVE) && sh_en_i;
  assign w_sample = (r_state == ACTIVE) && smp_en_i;
  assign w_last   = w_shift && (r_cnt == CNT_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tx_q <= '0;
      r_cnt  <= '0;
      r_len  <= '0;
      r_lsb  <= 1'b0;
    end else if (w_load) begin
      r_len  <= w_len;
      r_cnt  <= w_len;
      r_lsb  <= lsb_first_i;
      // MSB-first frames are left-aligned so the first bit sits at the top.
      r_tx_q <= lsb_first_i ? data_i : (data_i << (DATA_W - int'(w_len)));
    end else if (w_shift) begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_tx_q <= r_lsb ? (r_tx_q >> 1) : (r_tx_q << 1);
    end
  end

  assign ready_o = (r_state == IDLE);
  assign busy_o  = (r_state != IDLE);
  assign done_o  = (r_state == DONE);
  assign sdo_o   = (r_state == ACTIVE) ? (r_lsb ? r_tx_q[0] : r_tx_q[DATA_W-1]) : 1'b0;

`ifdef SPI_SHIFT_RX_EN
  spi_shift_rx #(.DATA_W(DATA_W)) u_rx (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_load      (w_load),
    .i_smp       (w_sample),
    .i_sdi       (sdi_i),
    .i_lsb_first (r_lsb),
    .i_len       (r_len),
    .i_fin       (w_last),
    .o_rx_data   (rx_data_o),
    .o_rx_valid  (rx_valid_o)
  );
`else
  logic w_unused;
  assign w_unused   = &{1'b0, w_sample, sdi_i, r_len};
  assign rx_data_o  = '0;
  assign rx_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed, table-driven bench for spi_shift_engine with sdi looped to sdo.
module tb_spi_shift_engine;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
`ifdef SPI_SHIFT_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] data_i = '0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic [CNT_W-1:0]  len_i = '0;
  logic              lsb_first_i = 1'b0;
  logic              sh_en_i = 1'b0;
  logic              smp_en_i = 1'b0;
  logic              sdi_i;
  logic              sdo_o, busy_o, done_o, rx_valid_o;
  logic [DATA_W-1:0] rx_data_o;

  int checks = 0;
  int failures = 0;

  assign sdi_i = sdo_o;
  always #5 clk = ~clk;

  spi_shift_engine #(.DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .len_i(len_i), .lsb_first_i(lsb_first_i), .sh_en_i(sh_en_i), .smp_en_i(smp_en_i),
    .sdi_i(sdi_i), .sdo_o(sdo_o), .busy_o(busy_o), .done_o(done_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o)
  );

  typedef struct {
    logic [31:0]      data;
    logic [CNT_W-1:0] len;
    logic             lsb;
    int               n;     // shifts the frame must take
    logic [31:0]      seq;   // expected sdo bits, first bit at [n-1]
    logic [31:0]      rx;
    bit               poke;  // drive a stray load while busy
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    logic [31:0] exp_rx;
    exp_rx = RX_EN ? v.rx : 32'h0;
    data_i = v.data; len_i = v.len; lsb_first_i = v.lsb; valid_i = 1'b1;
    chk($sformatf("f%0d_ready_at_load", idx), 32'(ready_o), 32'd1);
    tick();
    valid_i = 1'b0; data_i = '0; len_i = '0; lsb_first_i = 1'b0;
    chk($sformatf("f%0d_busy_after_load", idx), 32'(busy_o), 32'd1);
    chk($sformatf("f%0d_ready_after_load", idx), 32'(ready_o), 32'd0);
    for (int i = 0; i < v.n; i++) begin
      chk($sformatf("f%0d_sdo_bit%0d", idx, i), 32'(sdo_o), 32'(v.seq[v.n-1-i]));
      chk($sformatf("f%0d_no_early_done%0d", idx, i), 32'(done_o), 32'd0);
      if (v.poke && i == 3) begin
        valid_i = 1'b1; data_i = 32'hFF; len_i = 6'd8;
      end
      smp_en_i = 1'b1;
      tick();
      smp_en_i = 1'b0; valid_i = 1'b0; data_i = '0; len_i = '0;
      if (v.poke && i == 3)
        chk($sformatf("f%0d_ready_while_busy", idx), 32'(ready_o), 32'd0);
      sh_en_i = 1'b1;
      tick();
      sh_en_i = 1'b0;
    end
    chk($sformatf("f%0d_done", idx), 32'(done_o), 32'd1);
    chk($sformatf("f%0d_rx_valid", idx), 32'(rx_valid_o), 32'(RX_EN));
    chk($sformatf("f%0d_rx_data", idx), rx_data_o, exp_rx);
    chk($sformatf("f%0d_sdo_zero_fill", idx), 32'(sdo_o), 32'd0);
    chk($sformatf("f%0d_ready_in_done", idx), 32'(ready_o), 32'd0);
    tick();
    chk($sformatf("f%0d_ready_after_done", idx), 32'(ready_o), 32'd1);
    chk($sformatf("f%0d_busy_after_done", idx), 32'(busy_o), 32'd0);
    chk($sformatf("f%0d_done_one_cycle", idx), 32'(done_o), 32'd0);
    chk($sformatf("f%0d_rx_valid_one_cycle", idx), 32'(rx_valid_o), 32'd0);
    chk($sformatf("f%0d_rx_data_held", idx), rx_data_o, exp_rx);
  endtask

  initial begin
    tbl[0] = '{data: 32'h000000A5, len: 6'd8,  lsb: 1'b0, n: 8,  seq: 32'h000000A5, rx: 32'h000000A5, poke: 1'b0};
    tbl[1] = '{data: 32'h00000001, len: 6'd8,  lsb: 1'b1, n: 8,  seq: 32'h00000080, rx: 32'h00000001, poke: 1'b0};
    tbl[2] = '{data: 32'h00000016, len: 6'd5,  lsb: 1'b1, n: 5,  seq: 32'h0000000D, rx: 32'h00000016, poke: 1'b0};
    tbl[3] = '{data: 32'hDEADBEEF, len: 6'd0,  lsb: 1'b0, n: 32, seq: 32'hDEADBEEF, rx: 32'hDEADBEEF, poke: 1'b0};
    tbl[4] = '{data: 32'hDEADBEEF, len: 6'd40, lsb: 1'b0, n: 32, seq: 32'hDEADBEEF, rx: 32'hDEADBEEF, poke: 1'b0};
    tbl[5] = '{data: 32'h000000A5, len: 6'd8,  lsb: 1'b0, n: 8,  seq: 32'h000000A5, rx: 32'h000000A5, poke: 1'b1};

    tick(); tick();
    rst = 1'b0;
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_sdo", 32'(sdo_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("reset_rx_data", rx_data_o, 32'h0);

    for (int f = 0; f < 6; f++) run_frame(tbl[f], f);

    // Strobes in IDLE must not move anything.
    sh_en_i = 1'b1; smp_en_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("idle_strobe_busy%0d", c), 32'(busy_o), 32'd0);
      chk($sformatf("idle_strobe_ready%0d", c), 32'(ready_o), 32'd1);
      chk($sformatf("idle_strobe_sdo%0d", c), 32'(sdo_o), 32'd0);
      chk($sformatf("idle_strobe_done%0d", c), 32'(done_o), 32'd0);
      chk($sformatf("idle_strobe_rx%0d", c), rx_data_o, RX_EN ? 32'h000000A5 : 32'h0);
    end
    sh_en_i = 1'b0; smp_en_i = 1'b0;

    // Reset after the third shift of a len 8 frame.
    data_i = 32'hA5; len_i = 6'd8; lsb_first_i = 1'b0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp_en_i = 1'b1; tick(); smp_en_i = 1'b0;
      sh_en_i  = 1'b1; tick(); sh_en_i  = 1'b0;
    end
    chk("midrst_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_sdo", 32'(sdo_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_rx_valid", 32'(rx_valid_o), 32'd0);
    chk("midrst_rx_data", rx_data_o, 32'h0);
    run_frame(tbl[1], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Parametrised serial shift engine for the APB SPI Lite datapath. It is the successor to the fixed 8-bit left/right shifter. The block loads a word of up to DATA_W bits with a valid/ready handshake and serialises a run-time-selectable number of bits, MSB- or LSB-first. It optionally captures sdi into a receive word for full-duplex transfers. Bit timing comes from external strobes issued by the SPI clock generator.

## Interface
Parameters:
- DATA_W, 32, maximum frame width in bits (≥2)
- CNT_W, $clog2(DATA_W+1), derived localparam for length/counter width

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- data_i  in  DATA_W  transmit word, right-aligned
- valid_i  in  1  load request
- ready_o  out  1  engine can accept a load
- len_i  in  CNT_W  frame length in bits; 0 or >DATA_W means DATA_W
- lsb_first_i  in  1  1 = LSB-first, 0 = MSB-first
- sh_en_i  in  1  shift strobe (advance sdo_o, count one bit)
- smp_en_i  in  1  sample strobe (capture sdi_i)
- sdi_i  in  1  serial input
- sdo_o  out  1  serial output
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle end-of-frame pulse
- rx_data_o  out  DATA_W  received word, right-aligned, held until next done_o
- rx_valid_o  out  1  one-cycle pulse, coincident with done_o

## Operation
- FSM states: IDLE, ACTIVE, DONE.
- IDLE:
  - ready_o=1.
  - valid_i&&ready_o loads the frame, then goes to ACTIVE.
  - At load, latch len (clamped), lsb_first, and tx_q.
  - MSB-first: tx_q = data_i << (DATA_W-len). LSB-first: tx_q = data_i.
  - Bit counter = len.
  - Load rx_q with zero.
- ACTIVE:
  - sdo_o = tx_q[DATA_W-1] for MSB-first, tx_q[0] for LSB-first.
  - sh_en_i shifts tx_q toward sdo_o, filling with 0, and decrements the counter.
  - smp_en_i shifts sdi_i into rx_q: MSB-first shifts left, LSB-first shifts in from bit DATA_W-1 and shifts right.
  - Both strobes in the same cycle: both act; the sample uses the current sdi_i.
  - sh_en_i with counter==1 goes to DONE.
- DONE, one cycle:
  - done_o=1.
  - rx_data_o is updated with rx_q. For LSB-first, rx_q is right-aligned by >>(DATA_W-len).
  - rx_valid_o=1.
  - Next state is IDLE.
- busy_o=1 in ACTIVE and DONE.
- Strobes in IDLE or DONE are ignored.
- valid_i while ready_o=0 is ignored, not queued.
- data_i, len_i, and lsb_first_i are don't-care outside the load cycle.

## Timing
- Reset values: ready_o=1, busy_o=0, sdo_o=0, done_o=0, rx_valid_o=0, rx_data_o=0. State is IDLE and all counters and registers are 0.
- Load accepted at cycle N:
  - busy_o=1 and first bit on sdo_o at N+1.
  - ready_o=0 from N+1.
- sh_en_i at cycle k: the next bit is on sdo_o at k+1.
- Final sh_en_i at cycle k:
  - done_o, rx_valid_o, and the new rx_data_o appear at k+1.
  - ready_o=1 at k+2.
  - Minimum load-to-load spacing is len+2 cycles with continuous strobes.
- After the last shift, sdo_o=0 (zero fill).
- rst_i asserted mid-frame: IDLE on the next edge, outputs return to reset values, no done_o, and rx_data_o is cleared.

## Configuration
- SPI_SHIFT_RX_EN defined: the receive path is built. smp_en_i and sdi_i are used, and rx_data_o and rx_valid_o behave as above.
- SPI_SHIFT_RX_EN undefined: no rx_q register is built.
  - rx_data_o=0 and rx_valid_o=0 constantly.
  - smp_en_i and sdi_i are unused.
  - Ports remain present.
  - TX behaviour and done_o are unchanged.

## Structure
- Package spi_shift_pkg holds:
  - the typedef enum spi_shift_state_e {IDLE, ACTIVE, DONE};
  - a default-width constant SPI_DATA_W_DEF=32;
  - the length-clamp function.
- One sub-module, spi_shift_rx, holds the rx_q shift register and alignment. It is instantiated only under SPI_SHIFT_RX_EN.

## Test plan
All scenarios use DATA_W=32, SPI_SHIFT_RX_EN defined, and sdi_i looped to sdo_o. Sample precedes shift by at least 1 cycle.
- Reset: rst_i high 2 cycles -> ready_o=1, busy_o=0, sdo_o=0, done_o=0, rx_data_o=0.
- MSB-first, len 8, data 0xA5 -> sdo_o sequence 1,0,1,0,0,1,0,1. done_o one cycle after the 8th sh_en_i. rx_data_o=0x000000A5.
- LSB-first, len 8, data 0x01 -> sdo_o sequence 1,0,0,0,0,0,0,0. rx_data_o=0x00000001. Then len 5, data 0x16 -> sdo_o 0,1,1,0,1, rx_data_o=0x16.
- len_i=0 and len_i=40, MSB-first, data 0xDEADBEEF -> each frame is exactly 32 shifts, rx_data_o=0xDEADBEEF.
- valid_i with data 0xFF while busy, and sh_en_i pulses in IDLE -> load ignored, ready_o=0 until done, no state change in IDLE.
- rst_i pulsed after the 3rd sh_en_i of a len 8 frame -> IDLE next cycle, no done_o, sdo_o=0, a new load is accepted immediately.
